// File: rtl/multdiv_pkg.sv
// Shared definitions for the multi-cycle signed multiply/divide unit.
//   MD_WIDTH   : default operand/result width
//   MD_CNT_W   : default iteration counter width (must hold MD_WIDTH)
//   ITERATIONS : add/shift iterations per operation
//   INT_MIN    : most negative value at the default width
//   state_t    : controller state encoding
package multdiv_pkg;

   localparam int unsigned MD_WIDTH   = 32;
   localparam int unsigned MD_CNT_W   = 6;
   localparam int unsigned ITERATIONS = MD_WIDTH;

   localparam logic [MD_WIDTH-1:0] INT_MIN = {1'b1, {(MD_WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MULT = 2'd1,
      DIV  = 2'd2,
      DONE = 2'd3
   } state_t;

endpackage : multdiv_pkg

// File: rtl/addsub_33.sv
// Ripple-carry add/subtract built from full-adder cell equations.
//   a, b : operands
//   sub  : 0 -> a + b, 1 -> a + ~b + 1
//   sum  : W-bit result
//   cout : carry out of the top cell (for subtraction, 1 means no borrow)
module addsub_33 #(
   parameter int unsigned W = 33
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         sub,
   output logic [W-1:0] sum,
   output logic         cout
);

   logic carry;
   logic b_inv;

   // One full-adder cell per bit; carry threads through a local variable.
   always_comb begin
      sum   = '0;
      carry = sub;
      b_inv = 1'b0;
      for (int i = 0; i < int'(W); i++) begin
         b_inv  = b[i] ^ sub;
         sum[i] = a[i] ^ b_inv ^ carry;
         carry  = (a[i] & b_inv) | (carry & (a[i] ^ b_inv));
      end
      cout = carry;
   end

endmodule : addsub_33

// File: rtl/multdiv_ctrl.sv
// Multi-cycle signed multiply (radix-2 Booth) / divide (restoring, on
// magnitudes) sharing one WIDTH+1-bit add/subtract datapath.
// Both operations take a fixed WIDTH+1 edges from the start edge to the
// result strobe.
//   clock          : rising-edge clock
//   reset          : synchronous active-high reset
//   ctrl_MULT      : start pulse, multiply (wins over ctrl_DIV)
//   ctrl_DIV       : start pulse, divide
//   data_operandA  : multiplicand / dividend, sampled on a start edge
//   data_operandB  : multiplier / divisor, sampled on a start edge
//   data_result    : low word of product, or quotient
//   data_exception : signed overflow or divide-by-zero
//   data_resultRDY : one-cycle result-valid strobe
module multdiv_ctrl
   import multdiv_pkg::*;
#(
   parameter int unsigned WIDTH = MD_WIDTH,
   parameter int unsigned CNT_W = MD_CNT_W
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             ctrl_MULT,
   input  logic             ctrl_DIV,
   input  logic [WIDTH-1:0] data_operandA,
   input  logic [WIDTH-1:0] data_operandB,
   output logic [WIDTH-1:0] data_result,
   output logic             data_exception,
   output logic             data_resultRDY
);

   localparam logic [WIDTH-1:0] NEG_MIN  = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH:0]   acc;       // mult: sign-extended hi; div: remainder
   logic [WIDTH-1:0] lo;        // mult: lo/multiplier; div: quotient
   logic             q_m1;      // Booth q-1 bit
   logic [WIDTH-1:0] opr;       // mult: multiplicand; div: |divisor|
   logic             op_div;
   logic             neg_q;
   logic             div_zero;
   logic             div_ovf;

   logic             start;
   logic [WIDTH-1:0] abs_a;
   logic [WIDTH-1:0] abs_b;
   logic [WIDTH:0]   div_shift;
   logic             booth_add;
   logic [WIDTH:0]   mult_p;

   logic [WIDTH:0]   add_a;
   logic [WIDTH:0]   add_b;
   logic             add_sub;
   logic [WIDTH:0]   add_sum;
   logic             add_cout;

   assign start     = ctrl_MULT | ctrl_DIV;
   assign abs_a     = data_operandA[WIDTH-1] ? (~data_operandA + WIDTH'(1)) : data_operandA;
   assign abs_b     = data_operandB[WIDTH-1] ? (~data_operandB + WIDTH'(1)) : data_operandB;
   // Left shift of {R,Q} before the trial subtract.
   assign div_shift = {acc[WIDTH-1:0], lo[WIDTH-1]};
   // Booth pairs 01/10 add/subtract; 00/11 pass hi through untouched.
   assign booth_add = lo[0] ^ q_m1;
   assign mult_p    = booth_add ? add_sum : acc;

   // Operand steering for the shared adder; DONE reuses it to negate the quotient.
   always_comb begin
      add_a   = '0;
      add_b   = '0;
      add_sub = 1'b0;
      case (state)
         MULT: begin
            add_a   = acc;
            add_b   = {opr[WIDTH-1], opr};
            add_sub = lo[0] & ~q_m1;
         end
         DIV: begin
            add_a   = div_shift;
            add_b   = {1'b0, opr};
            add_sub = 1'b1;
         end
         DONE: begin
            add_a   = '0;
            add_b   = {1'b0, lo};
            add_sub = 1'b1;
         end
         default: ;
      endcase
   end

   addsub_33 #(.W(WIDTH + 1)) u_addsub (
      .a    (add_a),
      .b    (add_b),
      .sub  (add_sub),
      .sum  (add_sum),
      .cout (add_cout)
   );

   // Controller, iteration counter, shift registers and registered outputs.
   always_ff @(posedge clock) begin
      if (reset) begin
         state          <= IDLE;
         cnt            <= '0;
         acc            <= '0;
         lo             <= '0;
         q_m1           <= 1'b0;
         opr            <= '0;
         op_div         <= 1'b0;
         neg_q          <= 1'b0;
         div_zero       <= 1'b0;
         div_ovf        <= 1'b0;
         data_result    <= '0;
         data_exception <= 1'b0;
         data_resultRDY <= 1'b0;
      end else begin
         data_resultRDY <= 1'b0;
         if (start) begin
            // Any start pulse aborts whatever is in flight.
            cnt      <= '0;
            acc      <= '0;
            q_m1     <= 1'b0;
            neg_q    <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
            div_zero <= (data_operandB == '0);
            div_ovf  <= (data_operandA == NEG_MIN) && (data_operandB == '1);
            if (ctrl_MULT) begin
               state  <= MULT;
               op_div <= 1'b0;
               opr    <= data_operandA;
               lo     <= data_operandB;
            end else begin
               state  <= DIV;
               op_div <= 1'b1;
               opr    <= abs_b;
               lo     <= abs_a;
            end
         end else begin
            case (state)
               MULT: begin
                  // Arithmetic shift right of {hi, lo, q-1}.
                  acc  <= {mult_p[WIDTH], mult_p[WIDTH:1]};
                  lo   <= {mult_p[0], lo[WIDTH-1:1]};
                  q_m1 <= lo[0];
                  cnt  <= cnt + CNT_W'(1);
                  if (cnt == LAST_CNT) state <= DONE;
               end
               DIV: begin
                  // Carry out of the subtract means the trial remainder is non-negative.
                  acc <= add_cout ? add_sum : div_shift;
                  lo  <= {lo[WIDTH-2:0], add_cout};
                  cnt <= cnt + CNT_W'(1);
                  if (cnt == LAST_CNT) state <= DONE;
               end
               DONE: begin
                  state          <= IDLE;
                  data_resultRDY <= 1'b1;
                  if (!op_div) begin
                     data_result    <= lo;
                     data_exception <= (acc[WIDTH-1:0] != {WIDTH{lo[WIDTH-1]}});
                  end else if (div_zero) begin
                     data_result    <= '0;
                     data_exception <= 1'b1;
                  end else if (div_ovf) begin
                     data_result    <= NEG_MIN;
                     data_exception <= 1'b1;
                  end else begin
                     data_result    <= neg_q ? add_sum[WIDTH-1:0] : lo;
                     data_exception <= 1'b0;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule : multdiv_ctrl

// File: tb/tb_multdiv_ctrl.sv
// Scoreboard bench for multdiv_ctrl: each accepted start pushes its expected
// result, exception and start edge; the strobe monitor pops and compares,
// including the start-to-strobe latency.
module tb_multdiv_ctrl;
   import multdiv_pkg::*;

   localparam int unsigned W   = 32;
   localparam int unsigned LAT = 33;

   typedef struct packed {
      logic [W-1:0] res;
      logic         exc;
      logic [31:0]  e0;
   } exp_t;

   logic         clock;
   logic         reset;
   logic         ctrl_MULT;
   logic         ctrl_DIV;
   logic [W-1:0] data_operandA;
   logic [W-1:0] data_operandB;
   logic [W-1:0] data_result;
   logic         data_exception;
   logic         data_resultRDY;

   int unsigned  n_vec;
   int unsigned  n_err;
   logic [31:0]  edge_cnt;
   exp_t         sb[$];
   exp_t         mon_e;

   multdiv_ctrl #(.WIDTH(W), .CNT_W(6)) dut (
      .clock          (clock),
      .reset          (reset),
      .ctrl_MULT      (ctrl_MULT),
      .ctrl_DIV       (ctrl_DIV),
      .data_operandA  (data_operandA),
      .data_operandB  (data_operandB),
      .data_result    (data_result),
      .data_exception (data_exception),
      .data_resultRDY (data_resultRDY)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   initial edge_cnt = '0;
   always @(posedge clock) edge_cnt <= edge_cnt + 32'd1;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference model: {exception, result}.
   function automatic logic [W:0] model(input logic is_div, input logic [W-1:0] a, input logic [W-1:0] b);
      longint       p;
      logic [63:0]  pu;
      logic [W-1:0] q;
      if (!is_div) begin
         p  = longint'($signed(a)) * longint'($signed(b));
         pu = 64'(p);
         return {pu[63:32] != {32{pu[31]}}, pu[31:0]};
      end
      if (b == '0) return {1'b1, 32'd0};
      if (a == INT_MIN && b == '1) return {1'b1, INT_MIN};
      q = 32'($signed(a) / $signed(b));
      return {1'b0, q};
   endfunction

   // Strobe monitor, sampled on the falling edge.
   always @(negedge clock) begin
      if (!reset && data_resultRDY) begin
         if (sb.size() == 0) begin
            check("spurious_rdy", 64'(data_resultRDY), 64'd0);
         end else begin
            mon_e = sb.pop_front();
            check("result",    64'(data_result),           64'(mon_e.res));
            check("exception", 64'(data_exception),        64'(mon_e.exc));
            check("latency",   64'(edge_cnt - mon_e.e0),   64'(LAT));
         end
      end
   end

   task automatic start_op(input logic m, input logic d, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic push, input logic [W:0] expv);
      exp_t e;
      @(negedge clock);
      ctrl_MULT     = m;
      ctrl_DIV      = d;
      data_operandA = a;
      data_operandB = b;
      @(posedge clock);
      #1;
      ctrl_MULT     = 1'b0;
      ctrl_DIV      = 1'b0;
      data_operandA = $urandom();
      data_operandB = $urandom();
      if (push) begin
         e.res = expv[W-1:0];
         e.exc = expv[W];
         e.e0  = edge_cnt;
         sb.push_back(e);
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clock);
      check("drain", 64'(sb.size()), 64'd0);
      repeat (3) @(negedge clock);
   endtask

   task automatic run_op(input logic is_div, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W:0] expv);
      start_op(!is_div, is_div, a, b, 1'b1, expv);
      drain();
   endtask

   initial begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      n_vec         = 0;
      n_err         = 0;
      reset         = 1'b1;
      ctrl_MULT     = 1'b0;
      ctrl_DIV      = 1'b0;
      data_operandA = '0;
      data_operandB = '0;
      repeat (3) @(posedge clock);
      #1;
      check("reset_result", 64'(data_result),    64'd0);
      check("reset_exc",    64'(data_exception), 64'd0);
      check("reset_rdy",    64'(data_resultRDY), 64'd0);
      @(negedge clock);
      reset = 1'b0;

      // Directed multiplies
      run_op(1'b0, 32'd7,          32'hFFFF_FFFD, {1'b0, 32'hFFFF_FFEB});
      run_op(1'b0, 32'h0001_0000,  32'h0001_0000, {1'b1, 32'h0000_0000});
      run_op(1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF, {1'b0, 32'h0000_0001});
      run_op(1'b0, 32'h8000_0000,  32'hFFFF_FFFF, {1'b1, 32'h8000_0000});

      // Directed divides
      run_op(1'b1, 32'hFFFF_FFF9,  32'd2,         {1'b0, 32'hFFFF_FFFD});
      run_op(1'b1, 32'd7,          32'hFFFF_FFFE, {1'b0, 32'hFFFF_FFFD});
      run_op(1'b1, 32'd100,        32'd7,         {1'b0, 32'd14});
      run_op(1'b1, 32'h8000_0000,  32'hFFFF_FFFF, {1'b1, 32'h8000_0000});
      run_op(1'b1, 32'd5,          32'd0,         {1'b1, 32'd0});

      // Random operands against the reference model
      for (int i = 0; i < 6; i++) begin
         ra = $urandom();
         rb = (i < 3) ? 32'($urandom_range(0, 70000)) : $urandom();
         if (i[0]) rb = ~rb + 32'd1;
         run_op(1'b0, ra, rb, model(1'b0, ra, rb));
      end
      for (int i = 0; i < 6; i++) begin
         ra = $urandom();
         rb = 32'($urandom_range(1, 5000));
         if (i[0]) rb = ~rb + 32'd1;
         run_op(1'b1, ra, rb, model(1'b1, ra, rb));
      end

      // Restart: the multiply is aborted and never strobes
      start_op(1'b1, 1'b0, 32'd3, 32'd4, 1'b0, '0);
      repeat (9) @(posedge clock);
      start_op(1'b0, 1'b1, 32'd100, 32'd7, 1'b1, {1'b0, 32'd14});
      drain();

      // Reset five cycles into a multiply
      start_op(1'b1, 1'b0, 32'd9, 32'd9, 1'b0, '0);
      repeat (5) @(posedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      check("mid_reset_result", 64'(data_result),    64'd0);
      check("mid_reset_exc",    64'(data_exception), 64'd0);
      check("mid_reset_rdy",    64'(data_resultRDY), 64'd0);
      @(negedge clock);
      reset = 1'b0;
      repeat (40) @(negedge clock);

      // Both starts together: multiply wins
      run_op(1'b0, 32'd6, 32'd7, {1'b0, 32'd42});
      start_op(1'b1, 1'b1, 32'd6, 32'd7, 1'b1, {1'b0, 32'd42});
      drain();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule : tb_multdiv_ctrl
